// File: rtl/fs_pkg.sv
// rtl/fs_pkg.sv - single-bit full-subtractor equations shared by the fs datapath
//
// Purpose: holds the difference and borrow equations of one subtractor cell,
//          so every cell in the ripple chain uses the same definition.
// Ports:   none (package).
package fs_pkg;

  // Difference bit of a - b - bi.
  function automatic logic fs_diff(input logic a, input logic b, input logic bi);
    return a ^ b ^ bi;
  endfunction

  // Borrow-out: borrow when b exceeds a outright, or when a == b and a
  // borrow is coming in from the lower bit.
  function automatic logic fs_borrow(input logic a, input logic b, input logic bi);
    return (~a & b) | (~(a ^ b) & bi);
  endfunction

endpackage

// File: rtl/fs_bit.sv
// rtl/fs_bit.sv - combinational single-bit full-subtractor cell
//
// Purpose: one cell of the ripple-borrow chain, computing d = a - b - bi.
// Ports:
//   a   in   minuend bit
//   b   in   subtrahend bit
//   bi  in   borrow-in from the lower cell (or the chain borrow-in)
//   d   out  difference bit
//   bo  out  borrow-out to the next cell
module fs_bit
  import fs_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = fs_diff(a, b, bi);
  assign bo = fs_borrow(a, b, bi);

endmodule

// File: rtl/fs.sv
// rtl/fs.sv - registered ripple-borrow full subtractor
//
// Purpose: computes D = (A - B - Bin) mod 2^WIDTH and Bo = (A < B + Bin) on
//          unsigned operands, registering both on the rising clock edge.
// Parameters:
//   WIDTH  operand/difference width, 1..64
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset, clears D and Bo
//   A    in   minuend
//   B    in   subtrahend
//   Bin  in   borrow-in at bit 0
//   D    out  registered difference
//   Bo   out  registered borrow-out of the top cell
module fs #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bo
);

  // borrow[i] is the borrow into cell i; borrow[WIDTH] leaves the top cell.
  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff;

  assign borrow[0] = Bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fs_bit u_bit (
      .a  (A[i]),
      .b  (B[i]),
      .bi (borrow[i]),
      .d  (diff[i]),
      .bo (borrow[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D  <= '0;
      Bo <= 1'b0;
    end else begin
      D  <= diff;
      Bo <= borrow[WIDTH];
    end
  end

endmodule

// File: tb/tb_fs.sv
// tb/tb_fs.sv - scoreboard bench for fs at WIDTH=1 and WIDTH=8
module tb_fs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic       d1, bo1;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic [7:0] d8;
  logic       bo8;

  int total = 0;
  int bad   = 0;

  logic [1:0] q1[$];
  logic [8:0] q8[$];

  always #5 clk = ~clk;

  fs #(.WIDTH(1)) u_fs1 (
    .clk (clk), .rst (rst), .A (a1), .B (b1), .Bin (bin1), .D (d1), .Bo (bo1)
  );

  fs #(.WIDTH(8)) u_fs8 (
    .clk (clk), .rst (rst), .A (a8), .B (b8), .Bin (bin8), .D (d8), .Bo (bo8)
  );

  // Reference model: plain integer subtraction, sign gives the borrow.
  function automatic logic [1:0] model1(input logic a, input logic b, input logic bi);
    int diff;
    diff = int'(a) - int'(b) - int'(bi);
    return {diff[0], diff < 0};
  endfunction

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int diff;
    diff = int'(a) - int'(b) - int'(bi);
    return {diff[7:0], diff < 0};
  endfunction

  task automatic check1(input string tag, input logic [1:0] exp);
    total++;
    assert ({d1, bo1} === exp)
    else begin
      bad++;
      $error("FAIL %s w1: got D=%b Bo=%b expected D=%b Bo=%b", tag, d1, bo1, exp[1], exp[0]);
    end
  endtask

  task automatic check8(input string tag, input logic [8:0] exp);
    total++;
    assert ({d8, bo8} === exp)
    else begin
      bad++;
      $error("FAIL %s w8: got D=%h Bo=%b expected D=%h Bo=%b", tag, d8, bo8, exp[8:1], exp[0]);
    end
  endtask

  // Compare outputs from the previous edge, then drive the next vector and
  // queue its expectation for the following edge.
  task automatic pop_check(input string tag);
    if (q1.size() > 0) check1(tag, q1.pop_front());
    if (q8.size() > 0) check8(tag, q8.pop_front());
  endtask

  task automatic cycle(input string tag,
                       input logic x1, input logic y1, input logic z1,
                       input logic [7:0] x8, input logic [7:0] y8, input logic z8);
    @(negedge clk);
    pop_check(tag);
    a1 = x1; b1 = y1; bin1 = z1;
    a8 = x8; b8 = y8; bin8 = z8;
    q1.push_back(model1(x1, y1, z1));
    q8.push_back(model8(x8, y8, z8));
  endtask

  initial begin
    logic [2:0] v;

    // Reset state, no clock dependence
    #1;
    check1("reset_state", 2'b00);
    check8("reset_state", 9'h000);
    @(posedge clk); #1;
    check1("reset_hold", 2'b00);
    check8("reset_hold", 9'h000);

    // Release: first edge loads current inputs
    @(negedge clk);
    rst = 1'b0;
    q1.push_back(model1(a1, b1, bin1));
    q8.push_back(model8(a8, b8, bin8));

    // WIDTH=1 exhaustive, each held three cycles; WIDTH=8 directed alongside
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      for (int k = 0; k < 3; k++) begin
        case (i)
          0: cycle("exh", v[2], v[1], v[0], 8'h00, 8'h00, 1'b1);
          1: cycle("exh", v[2], v[1], v[0], 8'h80, 8'h01, 1'b0);
          2: cycle("exh", v[2], v[1], v[0], 8'hFF, 8'hFF, 1'b1);
          3: cycle("exh", v[2], v[1], v[0], 8'h10, 8'h0F, 1'b1);
          4: cycle("exh", v[2], v[1], v[0], 8'hFF, 8'h00, 1'b0);
          5: cycle("exh", v[2], v[1], v[0], 8'h00, 8'hFF, 1'b0);
          6: cycle("exh", v[2], v[1], v[0], 8'h00, 8'h00, 1'b0);
          default: cycle("exh", v[2], v[1], v[0], 8'h01, 8'h00, 1'b1);
        endcase
      end
    end

    // Latency: toggle every cycle
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) cycle("toggle", 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0);
      else            cycle("toggle", 1'b1, 1'b0, 1'b0, 8'h05, 8'h03, 1'b1);
    end

    // Mid-cycle asynchronous reset with nonzero outputs
    cycle("pre_rst", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    pop_check("pre_rst");
    @(posedge clk); #2;
    check1("nonzero_before_rst", 2'b11);
    check8("nonzero_before_rst", 9'h1FF);
    q1.delete();
    q8.delete();
    rst = 1'b1;
    #1;
    check1("async_rst", 2'b00);
    check8("async_rst", 9'h000);
    @(posedge clk); #1;
    check1("rst_held", 2'b00);
    check8("rst_held", 9'h000);
    @(negedge clk);
    rst = 1'b0;
    q1.push_back(model1(a1, b1, bin1));
    q8.push_back(model8(a8, b8, bin8));

    // Random vectors
    for (int i = 0; i < 1000; i++) begin
      cycle("rand", 1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom));
    end
    @(negedge clk);
    pop_check("rand_last");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
